// File: rtl/tvbg_run_scheduler.sv
// Run scheduler between the user button and the TV-B-Gone code controller:
// debounces the button, drives the start handshake, repeats sweeps and recovers faults.
//
// state | meaning
// IDLE  | waiting for a press, controller untouched
// START | ctrl_start_out high, waiting for controller busy
// RUN   | controller sweeping, watching busy fall / fail
// GAP   | idle gap between consecutive sweeps
// ABORT | second press seen, one-cycle controller reset
// FAULT | latched fault, waiting for a clearing press
module tvbg_run_scheduler #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEATS         = 2,
    parameter int GAP_CYCLES      = 1000000,
    parameter int START_TIMEOUT   = 255,
    parameter int CNT_WIDTH       = 24,
    parameter int RUN_WIDTH       = 4
) (
    input  logic                 clock_in,
    input  logic                 reset_n_in,
    input  logic                 button_in,
    input  logic                 ctrl_busy_in,
    input  logic                 ctrl_fail_in,
    output logic                 ctrl_start_out,
    output logic                 ctrl_reset_out,
    output logic                 active_out,
    output logic                 fault_out,
    output logic [RUN_WIDTH-1:0] run_index_out
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD = CNT_WIDTH'(GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(START_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [RUN_WIDTH-1:0] RUN_LAST = RUN_WIDTH'(REPEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        GAP   = 3'd3,
        ABORT = 3'd4,
        FAULT = 3'd5
    } state_t;

    logic                 sync_meta;
    logic                 sync_btn;
    logic                 btn_stable;
    logic [CNT_WIDTH-1:0] deb_cnt;
    logic                 press;

    state_t               state, state_nx;
    logic [RUN_WIDTH-1:0] run_idx, run_nx;
    logic [CNT_WIDTH-1:0] timer, timer_nx;
    logic                 rst_pulse, rst_pulse_nx;

    // The count never passes DEB_LAST, so it cannot wrap.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync_meta  <= 1'b0;
            sync_btn   <= 1'b0;
            btn_stable <= 1'b0;
            deb_cnt    <= '0;
            press      <= 1'b0;
        end else begin
            sync_meta <= button_in;
            sync_btn  <= sync_meta;
            press     <= 1'b0;
            if (sync_btn == btn_stable) begin
                deb_cnt <= '0;
            end else if (deb_cnt >= DEB_LAST) begin
                btn_stable <= sync_btn;
                deb_cnt    <= '0;
                press      <= sync_btn;
            end else begin
                deb_cnt <= deb_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state     <= IDLE;
            run_idx   <= '0;
            timer     <= '0;
            rst_pulse <= 1'b0;
        end else begin
            state     <= state_nx;
            run_idx   <= run_nx;
            timer     <= timer_nx;
            rst_pulse <= rst_pulse_nx;
        end
    end

    always_comb begin
        state_nx = state;
        run_nx   = run_idx;
        timer_nx = timer;
        case (state)
            IDLE: begin
                if (press) begin
                    state_nx = START;
                    run_nx   = '0;
                    timer_nx = '0;
                end
            end
            START: begin
                if (ctrl_fail_in) begin
                    state_nx = FAULT;
                end else if (press) begin
                    state_nx = ABORT;
                end else if (ctrl_busy_in) begin
                    state_nx = RUN;
                end else if (timer >= TO_LAST) begin
                    state_nx = FAULT;
                end else if (timer != CNT_MAX) begin
                    timer_nx = timer + CNT_WIDTH'(1);
                end
            end
            RUN: begin
                if (ctrl_fail_in) begin
                    state_nx = FAULT;
                end else if (press) begin
                    state_nx = ABORT;
                end else if (!ctrl_busy_in) begin
                    if (run_idx >= RUN_LAST) begin
                        state_nx = IDLE;
                        run_nx   = '0;
                    end else begin
                        state_nx = GAP;
                        run_nx   = run_idx + RUN_WIDTH'(1);
                        timer_nx = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (press) begin
                    state_nx = ABORT;
                end else if (timer == '0) begin
                    state_nx = START;
                end else begin
                    timer_nx = timer - CNT_WIDTH'(1);
                end
            end
            ABORT: begin
                state_nx = IDLE;
                run_nx   = '0;
            end
            FAULT: begin
                if (press) begin
                    state_nx = IDLE;
                    run_nx   = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                run_nx   = '0;
            end
        endcase
    end

    // Registered so the controller reset is a clean single-cycle pulse.
    always_comb begin
        rst_pulse_nx = 1'b0;
        if ((state_nx == ABORT) && (state != ABORT)) rst_pulse_nx = 1'b1;
        if ((state_nx == FAULT) && (state != FAULT)) rst_pulse_nx = 1'b1;
        if ((state == FAULT) && press)               rst_pulse_nx = 1'b1;
    end

    assign ctrl_start_out = (state == START);
    assign ctrl_reset_out = rst_pulse;
    assign active_out     = (state == START) || (state == RUN) ||
                            (state == GAP)   || (state == ABORT);
    assign fault_out      = (state == FAULT);
    assign run_index_out  = run_idx;

endmodule

// File: tb/tb_tvbg_run_scheduler.sv
// Directed bench for tvbg_run_scheduler with small debounce/gap/timeout values.
module tb_tvbg_run_scheduler;

    localparam int DEB = 4;
    localparam int REP = 2;
    localparam int GAP = 10;
    localparam int TO  = 8;
    localparam int CW  = 24;
    localparam int RW  = 4;

    logic          clock_in     = 1'b0;
    logic          reset_n_in   = 1'b0;
    logic          button_in    = 1'b0;
    logic          ctrl_busy_in = 1'b0;
    logic          ctrl_fail_in = 1'b0;
    logic          ctrl_start_out;
    logic          ctrl_reset_out;
    logic          active_out;
    logic          fault_out;
    logic [RW-1:0] run_index_out;

    int checks       = 0;
    int failures     = 0;
    int reset_pulses = 0;
    int start_seen   = 0;

    tvbg_run_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEATS        (REP),
        .GAP_CYCLES     (GAP),
        .START_TIMEOUT  (TO),
        .CNT_WIDTH      (CW),
        .RUN_WIDTH      (RW)
    ) dut (
        .clock_in      (clock_in),
        .reset_n_in    (reset_n_in),
        .button_in     (button_in),
        .ctrl_busy_in  (ctrl_busy_in),
        .ctrl_fail_in  (ctrl_fail_in),
        .ctrl_start_out(ctrl_start_out),
        .ctrl_reset_out(ctrl_reset_out),
        .active_out    (active_out),
        .fault_out     (fault_out),
        .run_index_out (run_index_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
        if (ctrl_reset_out === 1'b1) reset_pulses++;
        if (ctrl_start_out === 1'b1) start_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #23;
        chk("rst_start",  ctrl_start_out, 0);
        chk("rst_reset",  ctrl_reset_out, 0);
        chk("rst_active", active_out, 0);
        chk("rst_fault",  fault_out, 0);
        chk("rst_runidx", run_index_out, 0);
        reset_n_in = 1'b1;
        ticks(3);

        // 1. Bouncing button never reaches a press
        start_seen = 0;
        for (int i = 0; i < 20; i++) begin
            button_in = (i % 2 == 1);
            tick();
            chk("bounce_active", active_out, 0);
        end
        button_in = 1'b0;
        ticks(10);
        chk("bounce_start_seen", start_seen, 0);
        chk("bounce_idle", active_out, 0);

        // 2. Normal two-sweep run
        reset_pulses = 0;
        button_in = 1'b1;
        ticks(6);
        chk("run_start_early", ctrl_start_out, 0);
        tick();
        chk("run_start_lat7", ctrl_start_out, 1);
        chk("run_active0", active_out, 1);
        chk("run_idx0", run_index_out, 0);
        tick();
        ctrl_busy_in = 1'b1;
        tick();
        chk("run_start_drop", ctrl_start_out, 0);
        chk("run_active_run", active_out, 1);
        ticks(30);
        ctrl_busy_in = 1'b0;
        tick();
        chk("gap_idx1", run_index_out, 1);
        chk("gap_active", active_out, 1);
        start_seen = 0;
        ticks(9);
        chk("gap_no_start", start_seen, 0);
        tick();
        chk("gap_end_start", ctrl_start_out, 1);
        tick();
        ctrl_busy_in = 1'b1;
        tick();
        chk("run2_idx1", run_index_out, 1);
        chk("run2_start_drop", ctrl_start_out, 0);
        ticks(30);
        ctrl_busy_in = 1'b0;
        tick();
        chk("done_active", active_out, 0);
        chk("done_idx", run_index_out, 0);
        chk("done_no_reset", reset_pulses, 0);
        button_in = 1'b0;
        ticks(10);

        // 3. Start timeout then fault clear
        reset_pulses = 0;
        button_in = 1'b1;
        ticks(7);
        chk("to_start", ctrl_start_out, 1);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_not_yet", fault_out, 0);
        end
        tick();
        chk("to_fault", fault_out, 1);
        chk("to_reset", ctrl_reset_out, 1);
        chk("to_active", active_out, 0);
        chk("to_start_low", ctrl_start_out, 0);
        tick();
        chk("to_reset_single", ctrl_reset_out, 0);
        chk("to_fault_held", fault_out, 1);
        button_in = 1'b0;
        ticks(10);
        chk("to_pulse_count", reset_pulses, 1);
        start_seen = 0;
        button_in = 1'b1;
        ticks(7);
        chk("clr_fault", fault_out, 0);
        chk("clr_reset", ctrl_reset_out, 1);
        ticks(10);
        chk("clr_no_start", start_seen, 0);
        chk("clr_pulse_count", reset_pulses, 2);
        button_in = 1'b0;
        ticks(10);

        // 4. Fail and press in the same cycle during RUN
        button_in = 1'b1;
        ticks(7);
        ctrl_busy_in = 1'b1;
        tick();
        button_in = 1'b0;
        ticks(10);
        chk("fail_in_run", active_out, 1);
        button_in = 1'b1;
        ticks(6);
        ctrl_fail_in = 1'b1;
        tick();
        chk("fail_fault", fault_out, 1);
        chk("fail_idx", run_index_out, 0);
        chk("fail_active", active_out, 0);
        chk("fail_reset", ctrl_reset_out, 1);
        ctrl_fail_in = 1'b0;
        ctrl_busy_in = 1'b0;
        button_in = 1'b0;
        ticks(10);
        button_in = 1'b1;
        ticks(7);
        chk("fail_cleared", fault_out, 0);
        button_in = 1'b0;
        ticks(10);

        // 5. Abort during GAP
        button_in = 1'b1;
        ticks(7);
        chk("ab_start", ctrl_start_out, 1);
        ctrl_busy_in = 1'b1;
        tick();
        button_in = 1'b0;
        ticks(10);
        ctrl_busy_in = 1'b0;
        tick();
        chk("ab_gap_idx", run_index_out, 1);
        button_in = 1'b1;
        ticks(6);
        chk("ab_pre_reset", ctrl_reset_out, 0);
        chk("ab_pre_active", active_out, 1);
        tick();
        chk("ab_reset", ctrl_reset_out, 1);
        chk("ab_start_low", ctrl_start_out, 0);
        tick();
        chk("ab_idle", active_out, 0);
        chk("ab_reset_end", ctrl_reset_out, 0);
        chk("ab_idx", run_index_out, 0);
        start_seen = 0;
        ticks(15);
        chk("ab_no_start", start_seen, 0);
        button_in = 1'b0;
        ticks(10);

        // 6. Asynchronous reset mid-RUN, button held across release
        button_in = 1'b1;
        ticks(7);
        ctrl_busy_in = 1'b1;
        tick();
        chk("ar_in_run", active_out, 1);
        ticks(3);
        #3 reset_n_in = 1'b0;
        #1;
        chk("ar_start",  ctrl_start_out, 0);
        chk("ar_reset",  ctrl_reset_out, 0);
        chk("ar_active", active_out, 0);
        chk("ar_fault",  fault_out, 0);
        chk("ar_idx",    run_index_out, 0);
        ctrl_busy_in = 1'b0;
        #2 reset_n_in = 1'b1;
        ticks(6);
        chk("ar_start_early", ctrl_start_out, 0);
        tick();
        chk("ar_start_lat", ctrl_start_out, 1);
        chk("ar_active_start", active_out, 1);
        button_in = 1'b0;
        ticks(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
